// File: rtl/bram_stream_reader.sv
// Read-side streaming engine for a simple dual-port BRAM. It walks a wrapping address
// range and emits the words as a valid/ready stream through a credit-limited 4-entry FIFO.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int FIFO_DEPTH = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [2:0]          CREDITS = 3'd4;
  localparam logic [ADDR_WIDTH:0] REM_ONE = (ADDR_WIDTH+1)'(1);

  function automatic logic [ADDR_WIDTH-1:0] addr_wrap_inc(input logic [ADDR_WIDTH-1:0] a);
    return a + ADDR_WIDTH'(1);
  endfunction

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return p + 2'd1;
  endfunction

  logic [1:0]            state;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [2:0]            outstanding;

  logic                  issue_p0;
  logic                  last_p0;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [ADDR_WIDTH:0]   rem_src;

  logic                  vld_p1;
  logic                  last_p1;
  logic                  vld_p2;
  logic                  last_p2;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            fifo_count;

  logic                  push;
  logic                  pop;

  assign push = vld_p2;
  assign pop  = m_valid && m_ready;

  // In IDLE the first address issues on the same edge that accepts start,
  // which is what puts base_addr on rd_addr one cycle after the strobe.
  always_comb begin
    issue_p0   = 1'b0;
    issue_addr = next_addr;
    rem_src    = remaining;
    case (state)
      S_IDLE: begin
        issue_p0   = start && (length != '0);
        issue_addr = base_addr;
        rem_src    = length;
      end
      S_ISSUE: issue_p0 = (outstanding < CREDITS) || pop;
      default: ;
    endcase
  end

  assign last_p0 = (rem_src == REM_ONE);

  // Stage p0 -> p1/p2: command FSM, address issue and credit tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      done        <= 1'b0;
      remaining   <= '0;
      outstanding <= '0;
      rd_addr     <= '0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (length == '0) done  <= 1'b1;
            else              state <= last_p0 ? S_DRAIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue_p0 && last_p0) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && m_last) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (issue_p0) begin
        rd_addr   <= issue_addr;
        remaining <= rem_src - REM_ONE;
      end

      vld_p1 <= issue_p0;
      vld_p2 <= vld_p1;

      case ({issue_p0, pop})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (issue_p0) next_addr <= addr_wrap_inc(issue_addr);
    last_p1 <= issue_p0 && last_p0;
    last_p2 <= last_p1;
  end

  // Stage p2 -> FIFO: rd_data is valid in the cycle vld_p2 is high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= rd_data;
      fifo_last[wr_ptr] <= last_p2;
    end
  end

  assign m_valid = (fifo_count != '0);
  assign m_data  = m_valid ? fifo_data[rd_ptr] : '0;
  assign m_last  = m_valid && fifo_last[rd_ptr];
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: a command table run against a registered-read RAM model,
// with a scoreboard queue of expected beats, plus hand-written reset and back-to-back sequences.
module tb_bram_stream_reader;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  logic [DW-1:0] mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  // mode 0: m_ready held high; mode 1: m_ready pattern 1,0,0,1
  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            mode;
    int            poke;
    int            gap;
    int            exp_done;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q [$];
  vec_t  vecs [7];

  int nvec = 0;
  int nerr = 0;

  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int            beat_cnt;
  int            first_beat;
  int            busy_cnt;
  int            valid_cnt;
  int            done_cnt;
  int            max_out;
  logic          ovf;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_for(input int mode, input int k);
    if (mode == 0) return 1'b1;
    return (k % 4 == 0) || (k % 4 == 3);
  endfunction

  task automatic push_expected(input logic [AW-1:0] base, input logic [AW:0] len);
    beat_t b;
    for (int i = 0; i < int'(len); i++) begin
      logic [AW-1:0] a;
      a = base + AW'(i);
      b.data = mem[a];
      b.last = (i == int'(len) - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic clear_stats();
    beat_cnt   = 0;
    first_beat = -1;
    busy_cnt   = 0;
    valid_cnt  = 0;
    done_cnt   = 0;
    max_out    = 0;
    ovf        = 1'b0;
    prev_stall = 1'b0;
  endtask

  // Called once per cycle after inputs for that cycle are settled.
  task automatic observe(input int k, input int mode);
    beat_t b;
    m_ready = ready_for(mode, k);
    if (prev_stall)
      check("stall_hold", {30'd0, m_valid, m_last, m_data}, {30'd0, 1'b1, prev_last, prev_data});
    if (m_valid) valid_cnt++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (int'(dut.outstanding) > max_out) max_out = int'(dut.outstanding);
    if (dut.fifo_count == 3'd4 && dut.vld_p2 && !(m_valid && m_ready)) ovf = 1'b1;
    if (m_valid && m_ready) begin
      beat_cnt++;
      if (first_beat < 0) first_beat = k;
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL extra_beat: got data 0x%0h at cycle %0d, expected no beat", m_data, k);
      end else begin
        b = exp_q.pop_front();
        check($sformatf("beat%0d_data_last", beat_cnt), {31'd0, m_last, m_data}, {31'd0, b.last, b.data});
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
  endtask

  task automatic run_cmd(input vec_t v);
    int            done_cyc;
    int            limit;
    logic [AW-1:0] ea;
    done_cyc = -1;
    limit    = 4 * int'(v.len) + 40;
    clear_stats();
    push_expected(v.base, v.len);
    start     = 1'b1;
    base_addr = v.base;
    length    = v.len;
    m_ready   = ready_for(v.mode, 0);
    for (int k = 1; k <= limit && done_cyc < 0; k++) begin
      step();
      start = (k == v.poke);
      if (k == v.poke) begin
        base_addr = 8'h80;
        length    = 9'd3;
      end
      observe(k, v.mode);
      if (v.mode == 0 && k <= int'(v.len)) begin
        ea = v.base + AW'(k - 1);
        check($sformatf("rd_addr_c%0d", k), rd_addr, ea);
      end
      if (done) done_cyc = k;
    end
    start = 1'b0;
    if (done_cyc < 0) begin
      nvec++;
      nerr++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected a done pulse", limit);
    end else begin
      if (v.exp_done >= 0) check("done_cycle", done_cyc, v.exp_done);
      check("busy_at_done", busy, 1'b0);
    end
    check("beats_pending", exp_q.size(), 0);
    exp_q.delete();
    check("beat_count", beat_cnt, v.len);
    check("done_pulses", done_cnt, 1);
    if (v.mode == 0) begin
      check("busy_cycles", busy_cnt, (v.len == 0) ? 0 : int'(v.len) + 2);
      if (v.len != 0) check("first_beat_cycle", first_beat, 3);
    end
    if (v.len == 0) check("valid_cycles", valid_cnt, 0);
    check("outstanding_le4", max_out <= 4, 1'b1);
    check("fifo_overflow", ovf, 1'b0);
    for (int g = 0; g < v.gap; g++) begin
      step();
      if (g == 0) check("done_one_cycle", done, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   dn;
    int   vl;

    //            base    len      mode poke gap exp_done
    vecs[0] = '{8'h10, 9'd4,   0, -1, 0, 7};
    vecs[1] = '{8'hFE, 9'd4,   0, -1, 2, 7};
    vecs[2] = '{8'h20, 9'd16,  1, -1, 2, -1};
    vecs[3] = '{8'h05, 9'd1,   0, -1, 1, 4};
    vecs[4] = '{8'h33, 9'd0,   0, -1, 1, 1};
    vecs[5] = '{8'h00, 9'd256, 0, 10, 2, 259};
    vecs[6] = '{8'hF8, 9'd12,  1, -1, 1, -1};

    for (int i = 0; i < 256; i++) mem[i] = DW'(i * 3);

    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    m_ready   = 1'b0;
    repeat (3) step();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_rd_addr", rd_addr, 8'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    // Reset pulse in the middle of a length-8 command
    clear_stats();
    push_expected(8'h40, 9'd8);
    start     = 1'b1;
    base_addr = 8'h40;
    length    = 9'd8;
    m_ready   = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      start = 1'b0;
      if (k == 4) rst_n = 1'b0;
      else        observe(k, 0);
    end
    check("pre_reset_beats", beat_cnt, 1);
    step();
    rst_n = 1'b1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_m_valid", m_valid, 1'b0);
    check("mid_rst_m_last", m_last, 1'b0);
    check("mid_rst_m_data", m_data, 32'd0);
    check("mid_rst_rd_addr", rd_addr, 8'd0);
    exp_q.delete();
    dn = 0;
    vl = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (done) dn++;
      if (m_valid || busy) vl++;
    end
    check("post_rst_no_done", dn, 0);
    check("post_rst_idle_empty", vl, 0);

    v = '{8'h80, 9'd5, 0, -1, 1, 8};
    run_cmd(v);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
